// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and fixed-latency access sequencer that
// lets two cache-side clients share one single-port RAM.
//
// Handshake (both client ports): a client raises ReqN with WrN/AddrN/WDataN
// stable and holds it until AckN, a one-cycle completion pulse. The client
// must drop ReqN, or present a new request, in the cycle after AckN. A ReqN
// still high when the arbiter is back in IDLE is treated as a new access.
// A request is never aborted. Dropping ReqN mid-access still completes the
// access and still pulses AckN.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2   // strobe width in cycles, 1..15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Req0,
  input  logic          Wr0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] WData0,
  output logic          Ack0,
  output logic [DW-1:0] RData0,
  input  logic          Req1,
  input  logic          Wr1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData1,
  output logic          Ack1,
  output logic [DW-1:0] RData1,
  output logic [AW-1:0] MAddr,
  output logic [DW-1:0] MWData,
  output logic          MRd,
  output logic          MWr,
  input  logic [DW-1:0] MRData,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter reload: the number of strobe cycles remaining after the first one.
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          pick;

  // Next-state logic: arbitration in IDLE, latency countdown in ACCESS,
  // round-robin bookkeeping in DONE.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // A tie goes to the port that was not served last. A lone request wins.
    pick     = (Req0 && Req1) ? ~last_q : Req1;
    case (state_q)
      S_IDLE: begin
        if (Req0 || Req1) begin
          gnt_d    = pick;
          wr_d     = pick ? Wr1 : Wr0;
          maddr_d  = pick ? Addr1 : Addr0;
          mwdata_d = pick ? WData1 : WData0;
          cnt_d    = CNT_LOAD;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!wr_q) begin
            if (gnt_q) rdata1_d = MRData;
            else       rdata0_d = MRData;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. last resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes and acks are decoded from state, so an async reset kills them at once.
  assign MRd       = (state_q == S_ACCESS) && !wr_q;
  assign MWr       = (state_q == S_ACCESS) && wr_q;
  assign Ack0      = (state_q == S_DONE) && !gnt_q;
  assign Ack1      = (state_q == S_DONE) && gnt_q;
  assign MAddr     = maddr_q;
  assign MWData    = mwdata_q;
  assign RData0    = rdata0_q;
  assign RData1    = rdata1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a main LAT=2 instance with a RAM model,
// plus LAT=1 and LAT=15 instances for the latency boundaries.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- main instance (LAT=2) ----------------
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, mrd, mwr;
  logic [DW-1:0] rdata0, rdata1, mwdata, mrdata;
  logic [AW-1:0] maddr;
  logic [1:0]    state;

  logic [DW-1:0] ram [256];
  assign mrdata = ram[maddr[7:0]];
  always @(posedge CLK) if (mwr) ram[maddr[7:0]] <= mwdata;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(2)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(req0), .Wr0(wr0), .Addr0(addr0), .WData0(wdata0), .Ack0(ack0), .RData0(rdata0),
    .Req1(req1), .Wr1(wr1), .Addr1(addr1), .WData1(wdata1), .Ack1(ack1), .RData1(rdata1),
    .MAddr(maddr), .MWData(mwdata), .MRd(mrd), .MWr(mwr), .MRData(mrdata),
    .dbg_state(state)
  );

  // ---------------- LAT=1 and LAT=15 instances (port 0 reads only) ----------------
  logic          req_a, req_b;
  logic          zero1 = 1'b0;
  logic [AW-1:0] zero_a = '0;
  logic [DW-1:0] zero_d = '0;
  logic [DW-1:0] mrdata_a = 32'hA5A5_0001;
  logic [DW-1:0] mrdata_b = 32'hA5A5_000F;
  logic          ack0_a, ack1_a, mrd_a, mwr_a, ack0_b, ack1_b, mrd_b, mwr_b;
  logic [DW-1:0] rdata0_a, rdata1_a, mwdata_a, rdata0_b, rdata1_b, mwdata_b;
  logic [AW-1:0] maddr_a, maddr_b;
  logic [1:0]    state_a, state_b;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(1)) dut_l1 (
    .CLK(CLK), .RST(RST),
    .Req0(req_a), .Wr0(zero1), .Addr0(zero_a), .WData0(zero_d), .Ack0(ack0_a), .RData0(rdata0_a),
    .Req1(zero1), .Wr1(zero1), .Addr1(zero_a), .WData1(zero_d), .Ack1(ack1_a), .RData1(rdata1_a),
    .MAddr(maddr_a), .MWData(mwdata_a), .MRd(mrd_a), .MWr(mwr_a), .MRData(mrdata_a),
    .dbg_state(state_a)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(15)) dut_l15 (
    .CLK(CLK), .RST(RST),
    .Req0(req_b), .Wr0(zero1), .Addr0(zero_a), .WData0(zero_d), .Ack0(ack0_b), .RData0(rdata0_b),
    .Req1(zero1), .Wr1(zero1), .Addr1(zero_a), .WData1(zero_d), .Ack1(ack1_b), .RData1(rdata1_b),
    .MAddr(maddr_b), .MWData(mwdata_b), .MRd(mrd_b), .MWr(mwr_b), .MRData(mrdata_b),
    .dbg_state(state_b)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Measure strobe width and ack cycle of a port 0 read on the LAT=1 or LAT=15 instance.
  task automatic run_lat(input bit sel_b, output int width, output int ack_cyc);
    width   = 0;
    ack_cyc = -1;
    if (sel_b) req_b = 1'b1; else req_a = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (sel_b ? mrd_b : mrd_a) width++;
      if ((sel_b ? ack0_b : ack0_a) && ack_cyc < 0) begin
        ack_cyc = c;
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  int w, ac;

  // ---------------- directed stimulus ----------------
  initial begin
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    req_a = 0; req_b = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'hC000_0000 | i;
    ram[8'h10] = 32'hDEAD_BEEF;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst_mrd", {31'b0, mrd}, 32'd0);
    chk("rst_mwr", {31'b0, mwr}, 32'd0);
    chk("rst_ack", {30'b0, ack1, ack0}, 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_mwdata", mwdata, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_state", {30'b0, state}, 32'd0);

    // Single read port 0 of 0x10 (cycle 0 = now)
    req0 = 1; wr0 = 0; addr0 = 32'h10;
    tick();
    chk("rd0_c1_mrd", {31'b0, mrd}, 32'd1);
    chk("rd0_c1_mwr", {31'b0, mwr}, 32'd0);
    chk("rd0_c1_maddr", maddr, 32'h10);
    tick();
    chk("rd0_c2_mrd", {31'b0, mrd}, 32'd1);
    chk("rd0_c2_ack0", {31'b0, ack0}, 32'd0);
    tick();
    chk("rd0_c3_ack0", {31'b0, ack0}, 32'd1);
    chk("rd0_c3_ack1", {31'b0, ack1}, 32'd0);
    chk("rd0_c3_mrd", {31'b0, mrd}, 32'd0);
    chk("rd0_c3_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("rd0_c3_rdata1", rdata1, 32'd0);
    req0 = 0;
    tick();
    chk("rd0_c4_ack0", {31'b0, ack0}, 32'd0);
    chk("rd0_c4_state", {30'b0, state}, 32'd0);

    // Single write port 1: 0x12345678 -> 0x20
    req1 = 1; wr1 = 1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
    tick();
    chk("wr1_c1_mwr", {31'b0, mwr}, 32'd1);
    chk("wr1_c1_mrd", {31'b0, mrd}, 32'd0);
    chk("wr1_c1_maddr", maddr, 32'h20);
    chk("wr1_c1_mwdata", mwdata, 32'h1234_5678);
    tick();
    chk("wr1_c2_mwr", {31'b0, mwr}, 32'd1);
    tick();
    chk("wr1_c3_ack1", {31'b0, ack1}, 32'd1);
    chk("wr1_c3_ack0", {31'b0, ack0}, 32'd0);
    chk("wr1_c3_mwr", {31'b0, mwr}, 32'd0);
    chk("wr1_c3_rdata1", rdata1, 32'd0);
    chk("wr1_c3_rdata0", rdata0, 32'hDEAD_BEEF);
    req1 = 0; wr1 = 0;
    tick();

    // Port 0 reads back 0x20
    req0 = 1; wr0 = 0; addr0 = 32'h20;
    tick(); tick(); tick();
    chk("rb0_ack0", {31'b0, ack0}, 32'd1);
    chk("rb0_rdata0", rdata0, 32'h1234_5678);
    req0 = 0;
    tick();

    // Reset in the middle of an access
    req0 = 1; addr0 = 32'h30;
    tick();
    chk("rstmid_mrd_before", {31'b0, mrd}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rstmid_mrd_same", {31'b0, mrd}, 32'd0);
    chk("rstmid_state_same", {30'b0, state}, 32'd0);
    req0 = 0;
    tick();
    chk("rstmid_ack0", {31'b0, ack0}, 32'd0);
    RST = 1'b0;
    tick(); tick(); tick();
    chk("rstmid_ack_after", {30'b0, ack1, ack0}, 32'd0);
    chk("rstmid_strobes_after", {30'b0, mwr, mrd}, 32'd0);
    chk("rstmid_rdata0", rdata0, 32'd0);
    chk("rstmid_maddr", maddr, 32'd0);
    chk("rstmid_state", {30'b0, state}, 32'd0);

    // Simultaneous reads from reset: port 0 first, port 1 acks at cycle 7
    req0 = 1; addr0 = 32'h30; req1 = 1; wr1 = 0; addr1 = 32'h40;
    tick();
    chk("sim_c1_maddr", maddr, 32'h30);
    tick(); tick();
    chk("sim_c3_ack0", {31'b0, ack0}, 32'd1);
    chk("sim_c3_ack1", {31'b0, ack1}, 32'd0);
    chk("sim_c3_rdata0", rdata0, 32'hC000_0030);
    req0 = 0;
    tick();
    chk("sim_c4_state", {30'b0, state}, 32'd0);
    tick();
    chk("sim_c5_maddr", maddr, 32'h40);
    chk("sim_c5_mrd", {31'b0, mrd}, 32'd1);
    tick();
    chk("sim_c6_ack1", {31'b0, ack1}, 32'd0);
    tick();
    chk("sim_c7_ack1", {31'b0, ack1}, 32'd1);
    chk("sim_c7_ack0", {31'b0, ack0}, 32'd0);
    chk("sim_c7_rdata1", rdata1, 32'hC000_0040);
    req1 = 0;
    tick();

    // Both held continuously: grants alternate 0,1,0,1
    req0 = 1; addr0 = 32'h50; req1 = 1; addr1 = 32'h60;
    for (int k = 0; k < 4; k++) begin
      tick(); tick(); tick();
      chk($sformatf("alt%0d_ack0", k), {31'b0, ack0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_ack1", k), {31'b0, ack1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
      tick();
    end
    chk("alt_rdata0", rdata0, 32'hC000_0050);
    chk("alt_rdata1", rdata1, 32'hC000_0060);
    chk("alt_end_state", {30'b0, state}, 32'd0);

    // Req0 dropped in cycle 1 of ACCESS: access still completes
    req0 = 1; addr0 = 32'h70;
    tick();
    req0 = 0;
    chk("drop_c1_mrd", {31'b0, mrd}, 32'd1);
    tick();
    chk("drop_c2_mrd", {31'b0, mrd}, 32'd1);
    tick();
    chk("drop_c3_ack0", {31'b0, ack0}, 32'd1);
    chk("drop_c3_rdata0", rdata0, 32'hC000_0070);
    tick();
    chk("drop_c4_ack0", {31'b0, ack0}, 32'd0);
    chk("drop_c4_mrd", {31'b0, mrd}, 32'd0);
    tick();
    chk("drop_c5_state", {30'b0, state}, 32'd0);

    // Latency boundaries
    run_lat(1'b0, w, ac);
    chk("lat1_width", w, 32'd1);
    chk("lat1_ack_cycle", ac, 32'd2);
    chk("lat1_rdata0", rdata0_a, 32'hA5A5_0001);
    run_lat(1'b1, w, ac);
    chk("lat15_width", w, 32'd15);
    chk("lat15_ack_cycle", ac, 32'd16);
    chk("lat15_rdata0", rdata0_b, 32'hA5A5_000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer for the single-port main RAM behind the cache. It sits between two memory clients (port 0: instruction-side cache refill, port 1: data-side cache / write-through path) and the RAM. It grants one client at a time round-robin, holds the RAM read/write strobes for a fixed multi-cycle access time, and returns read data with a one-cycle acknowledge. This lets two caches share one RAM without bus contention on the RAM data lines.

## Interface
- AW, 32, address width
- DW, 32, data width
- LAT, 2, RAM access time in cycles (strobe held this long); legal range 1..15

- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- Req0  in  1  port 0 request, level, held until Ack0
- Wr0  in  1  port 0 write (1) / read (0), valid while Req0
- Addr0  in  AW  port 0 address, valid while Req0
- WData0  in  DW  port 0 write data, valid while Req0 & Wr0
- Ack0  out  1  port 0 completion, one-cycle pulse
- RData0  out  DW  port 0 read data, valid from Ack0 cycle, held until next port 0 read completes
- Req1, Wr1, Addr1, WData1, Ack1, RData1: identical for port 1
- MAddr  out  AW  RAM address (registered at grant)
- MWData  out  DW  RAM write data (registered at grant)
- MRd  out  1  RAM read strobe
- MWr  out  1  RAM write strobe
- MRData  in  DW  RAM read data, sampled on last access cycle

## Operation
- States: IDLE, ACCESS, DONE. Registers: state, gnt (granted port), last (last granted port), cnt (4 bits), wr latch, MAddr, MWData, RData0, RData1.
- IDLE: if neither Req: stay. If one Req: grant it. If both: grant port != last. On grant edge: gnt<=port, wr<=WrN, MAddr<=AddrN, MWData<=WDataN, cnt<=LAT-1, state<=ACCESS.
- ACCESS: MRd = ~wr, MWr = wr (combinational from state==ACCESS; both 0 in all other states). Each edge: if cnt==0 then state<=DONE and, if read, RData[gnt]<=MRData; else cnt<=cnt-1.
- DONE: Ack[gnt]=1 (decoded from state, the other Ack 0). Edge: last<=gnt, state<=IDLE.
- Write accesses leave RData0/RData1 unchanged. MAddr/MWData hold their last value outside ACCESS.
- Req dropped during ACCESS: access completes, Ack still pulses (no abort).
- Requester must drop Req (or present a new request) in the cycle after Ack; Req still high in IDLE is a new access.
- MRd and MWr never both 1; Ack0 and Ack1 never both 1.

## Timing
- Reset (async, immediate): state=IDLE, last=1 (port 0 wins first tie), cnt=0, wr=0, MAddr=0, MWData=0, RData0=RData1=0; hence MRd=MWr=Ack0=Ack1=0.
- Reset mid-ACCESS/DONE: strobes and Ack drop in the same cycle RST rises; no Ack issued; the access is lost.
- Req sampled in cycle 0 (IDLE) -> strobe cycles 1..LAT -> Ack in cycle LAT+1 -> IDLE in cycle LAT+2. Service time LAT+2 cycles; throughput one access per LAT+2 cycles.
- Losing requester waits; it is granted in the IDLE cycle after the winner's DONE, total wait 2*(LAT+2) cycles from a simultaneous request.
- Simultaneous Req in IDLE after a port-N access: the other port wins. Continuous requests from both ports alternate 0,1,0,1.
- LAT=1: single strobe cycle, cnt loaded 0.

## Test plan
- Reset: RST=1 mid-ACCESS (LAT=2) -> MRd falls same cycle, no Ack, after release all outputs 0, state IDLE.
- Single read port 0, Addr0=0x10, RAM[0x10]=0xDEADBEEF, LAT=2 -> MRd high cycles 1-2, MAddr=0x10, Ack0 cycle 3 with RData0=0xDEADBEEF, RData1 unchanged.
- Single write port 1, Addr1=0x20, WData1=0x12345678 -> MWr high 2 cycles, MWData=0x12345678, Ack1 cycle 3; later port 0 read of 0x20 returns 0x12345678.
- Simultaneous Req0/Req1 reads from reset -> port 0 Ack at cycle 3, port 1 Ack at cycle 7; both held continuously -> grants alternate 0,1,0,1.
- Req0 dropped in cycle 1 of ACCESS -> access completes, Ack0 still pulses cycle 3.
- LAT=1 and LAT=15 builds -> strobe width exactly 1 and 15 cycles, Ack at cycle LAT+1.
